// File: rtl/vga_timing_gen.sv
// Raster timing generator: free-running pixel/line counters with sync and
// display-enable decode, a pixel-step delay line and a frame-start pulse.
module vga_timing_gen #(
    parameter int PIX_WIDTH  = 12,
    parameter int H_VISIBLE  = 1280,
    parameter int H_FRONT    = 48,
    parameter int H_SYNC     = 112,
    parameter int H_BACK     = 248,
    parameter int V_VISIBLE  = 1024,
    parameter int V_FRONT    = 1,
    parameter int V_SYNC     = 3,
    parameter int V_BACK     = 38,
    parameter int H_SYNC_POL = 1,
    parameter int V_SYNC_POL = 1,
    parameter int SYNC_DELAY = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 pix_ce_i,
    output logic [PIX_WIDTH-1:0] pix_x_o,
    output logic [PIX_WIDTH-1:0] pix_y_o,
    output logic                 hsync_o,
    output logic                 vsync_o,
    output logic                 de_o,
    output logic                 frame_start_o
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [PIX_WIDTH-1:0] H_LAST     = PIX_WIDTH'(H_TOTAL - 1);
    localparam logic [PIX_WIDTH-1:0] V_LAST     = PIX_WIDTH'(V_TOTAL - 1);
    localparam logic [PIX_WIDTH-1:0] H_DE_END   = PIX_WIDTH'(H_VISIBLE);
    localparam logic [PIX_WIDTH-1:0] V_DE_END   = PIX_WIDTH'(V_VISIBLE);
    localparam logic [PIX_WIDTH-1:0] H_SS       = PIX_WIDTH'(H_VISIBLE + H_FRONT);
    localparam logic [PIX_WIDTH-1:0] H_SE       = PIX_WIDTH'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [PIX_WIDTH-1:0] V_SS       = PIX_WIDTH'(V_VISIBLE + V_FRONT);
    localparam logic [PIX_WIDTH-1:0] V_SE       = PIX_WIDTH'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam logic                 HS_ON      = (H_SYNC_POL != 0);
    localparam logic                 VS_ON      = (V_SYNC_POL != 0);

    logic [PIX_WIDTH-1:0] h_cnt_q, h_cnt_d;
    logic [PIX_WIDTH-1:0] v_cnt_q, v_cnt_d;
    logic                 frame_start_q, frame_start_d;
    logic                 line_wrap;
    logic                 de_raw, hs_raw, vs_raw;

    // v_cnt moves on the same edge h_cnt wraps, so (0, stale y) never appears.
    always_comb begin
        h_cnt_d       = h_cnt_q;
        v_cnt_d       = v_cnt_q;
        line_wrap     = (h_cnt_q == H_LAST);
        frame_start_d = pix_ce_i && line_wrap && (v_cnt_q == V_LAST);
        if (pix_ce_i) begin
            if (line_wrap) begin
                h_cnt_d = '0;
                v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
            end else begin
                h_cnt_d = h_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            frame_start_q <= 1'b0;
        end else begin
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            frame_start_q <= frame_start_d;
        end
    end

    always_comb begin
        de_raw = (h_cnt_q < H_DE_END) && (v_cnt_q < V_DE_END);
        hs_raw = ((h_cnt_q >= H_SS) && (h_cnt_q < H_SE)) ? HS_ON : ~HS_ON;
        vs_raw = ((v_cnt_q >= V_SS) && (v_cnt_q < V_SE)) ? VS_ON : ~VS_ON;
    end

    generate
        if (SYNC_DELAY == 0) begin : g_no_delay
            assign hsync_o = hs_raw;
            assign vsync_o = vs_raw;
            assign de_o    = de_raw;
        end else begin : g_delay
            // Bit 0 takes the fresh decode; the MSB is the oldest stage.
            logic [SYNC_DELAY-1:0] de_pipe_q, de_pipe_d;
            logic [SYNC_DELAY-1:0] hs_pipe_q, hs_pipe_d;
            logic [SYNC_DELAY-1:0] vs_pipe_q, vs_pipe_d;

            always_comb begin
                de_pipe_d = de_pipe_q;
                hs_pipe_d = hs_pipe_q;
                vs_pipe_d = vs_pipe_q;
                if (pix_ce_i) begin
                    de_pipe_d = SYNC_DELAY'({de_pipe_q, de_raw});
                    hs_pipe_d = SYNC_DELAY'({hs_pipe_q, hs_raw});
                    vs_pipe_d = SYNC_DELAY'({vs_pipe_q, vs_raw});
                end
            end

            always_ff @(posedge clk_i) begin
                if (!rst_n_i) begin
                    de_pipe_q <= '0;
                    hs_pipe_q <= {SYNC_DELAY{~HS_ON}};
                    vs_pipe_q <= {SYNC_DELAY{~VS_ON}};
                end else begin
                    de_pipe_q <= de_pipe_d;
                    hs_pipe_q <= hs_pipe_d;
                    vs_pipe_q <= vs_pipe_d;
                end
            end

            assign hsync_o = hs_pipe_q[SYNC_DELAY-1];
            assign vsync_o = vs_pipe_q[SYNC_DELAY-1];
            assign de_o    = de_pipe_q[SYNC_DELAY-1];
        end
    endgenerate

    assign pix_x_o       = h_cnt_q;
    assign pix_y_o       = v_cnt_q;
    assign frame_start_o = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a 16x8 raster: one instance with a two-step
// sync delay and one with no delay, both checked against a step-count model.
module tb_vga_timing_gen;
    localparam int PW = 12;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ce = 1'b0;
    logic [PW-1:0] x2, y2, x0, y0;
    logic          hs2, vs2, de2, fs2;
    logic          hs0, vs0, de0, fs0;

    int total = 0;
    int bad = 0;
    bit chk_en = 1'b0;
    int n = 0;          // pixel steps taken since the last reset
    bit fs_exp = 1'b0;

    always #5 clk = ~clk;

    vga_timing_gen #(
        .PIX_WIDTH(PW), .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
        .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
        .H_SYNC_POL(0), .V_SYNC_POL(0), .SYNC_DELAY(2)
    ) dut_d2 (
        .clk_i(clk), .rst_n_i(rst_n), .pix_ce_i(ce),
        .pix_x_o(x2), .pix_y_o(y2), .hsync_o(hs2), .vsync_o(vs2),
        .de_o(de2), .frame_start_o(fs2)
    );

    vga_timing_gen #(
        .PIX_WIDTH(PW), .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
        .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
        .H_SYNC_POL(0), .V_SYNC_POL(0), .SYNC_DELAY(0)
    ) dut_d0 (
        .clk_i(clk), .rst_n_i(rst_n), .pix_ce_i(ce),
        .pix_x_o(x0), .pix_y_o(y0), .hsync_o(hs0), .vsync_o(vs0),
        .de_o(de0), .frame_start_o(fs0)
    );

    // Raster rules for step m of a 16-pixel x 8-line frame, sync active low.
    function automatic bit de_at(int m);
        return ((m % 16) < 8) && (((m / 16) % 8) < 4);
    endfunction
    function automatic bit hs_at(int m);
        return !(((m % 16) >= 10) && ((m % 16) <= 12));
    endfunction
    function automatic bit vs_at(int m);
        return !((((m / 16) % 8) >= 5) && (((m / 16) % 8) <= 6));
    endfunction
    function automatic bit exp_de(int d);
        return (n < d) ? 1'b0 : de_at(n - d);
    endfunction
    function automatic bit exp_hs(int d);
        return (n < d) ? 1'b1 : hs_at(n - d);
    endfunction
    function automatic bit exp_vs(int d);
        return (n < d) ? 1'b1 : vs_at(n - d);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t step=%0d)", name, act, exp, $time, n);
        end
    endtask

    always @(posedge clk) begin
        if (!rst_n) begin
            n = 0;
            fs_exp = 1'b0;
        end else begin
            fs_exp = 1'b0;
            if (ce) begin
                n = n + 1;
                if (n % 128 == 0) fs_exp = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("x_d2", 32'(x2), 32'(n % 16));
            check("y_d2", 32'(y2), 32'((n / 16) % 8));
            check("de_d2", 32'(de2), 32'(exp_de(2)));
            check("hs_d2", 32'(hs2), 32'(exp_hs(2)));
            check("vs_d2", 32'(vs2), 32'(exp_vs(2)));
            check("fs_d2", 32'(fs2), 32'(fs_exp));
            check("x_d0", 32'(x0), 32'(n % 16));
            check("y_d0", 32'(y0), 32'((n / 16) % 8));
            check("de_d0", 32'(de0), 32'(exp_de(0)));
            check("hs_d0", 32'(hs0), 32'(exp_hs(0)));
            check("vs_d0", 32'(vs0), 32'(exp_vs(0)));
            check("fs_d0", 32'(fs0), 32'(fs_exp));
        end
    end

    task automatic cyc(input bit r, input bit c);
        rst_n = r;
        ce = c;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int fs_cnt, fs_at, de_cnt, hs_low, vs_low;
        int fs_a, fs_b, guard;

        cyc(1'b0, 1'b0);
        chk_en = 1'b1;
        cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b0);
        check("rst_x", 32'(x2), 0);
        check("rst_y", 32'(y2), 0);
        check("rst_de", 32'(de2), 0);
        check("rst_hs", 32'(hs2), 1);
        check("rst_vs", 32'(vs2), 1);
        check("rst_fs", 32'(fs2), 0);
        check("rst_de_nodelay", 32'(de0), 1);

        fs_cnt = 0; fs_at = -1; de_cnt = 0; hs_low = 0; vs_low = 0;
        for (int i = 0; i < 128; i++) begin
            cyc(1'b1, 1'b1);
            if (fs2) begin
                fs_cnt++;
                fs_at = i + 1;
            end
            de_cnt += int'(de2);
            hs_low += int'(!hs2);
            vs_low += int'(!vs2);
            if (i == 9) begin
                check("hs_d2_at_x10", 32'(hs2), 1);
                check("hs_d0_at_x10", 32'(hs0), 0);
            end
            if (i == 11) begin
                check("x_at_12", 32'(x2), 12);
                check("hs_d2_at_x12", 32'(hs2), 0);
            end
        end
        check("fs_count_128", 32'(fs_cnt), 1);
        check("fs_clock", 32'(fs_at), 128);
        check("de_high_clocks", 32'(de_cnt), 32);
        check("hs_low_clocks", 32'(hs_low), 24);
        check("vs_low_clocks", 32'(vs_low), 32);

        fs_a = -1; fs_b = -1; fs_cnt = 0;
        for (int i = 0; i < 600; i++) begin
            cyc(1'b1, (i % 2) == 0);
            if (fs2) begin
                fs_cnt++;
                if (fs_a < 0) fs_a = i;
                else if (fs_b < 0) fs_b = i;
            end
        end
        check("fs_count_toggle", 32'(fs_cnt), 2);
        check("fs_period_toggle", 32'(fs_b - fs_a), 256);

        guard = 0;
        while ((n % 128) != 89 && guard < 300) begin
            cyc(1'b1, 1'b1);
            guard++;
        end
        check("reach_9_5", 32'(n % 128), 89);
        check("pre_rst_x", 32'(x2), 9);
        check("pre_rst_y", 32'(y2), 5);
        cyc(1'b0, 1'b1);
        check("mid_rst_x", 32'(x2), 0);
        check("mid_rst_y", 32'(y2), 0);
        check("mid_rst_de", 32'(de2), 0);
        check("mid_rst_hs", 32'(hs2), 1);
        check("mid_rst_vs", 32'(vs2), 1);
        check("mid_rst_fs", 32'(fs2), 0);
        cyc(1'b1, 1'b1);
        check("rel1_de", 32'(de2), 0);
        cyc(1'b1, 1'b1);
        check("rel2_de", 32'(de2), 1);
        for (int i = 0; i < 20; i++) cyc(1'b1, 1'b1);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
